// File: rtl/conv_filter_pkg.sv
// conv_filter_pkg: shared types, kernel constants and channel arithmetic for conv_filter
package conv_filter_pkg;
  localparam int LATENCY = 4;
  localparam int COEFF_W_MAX = 16;
  typedef enum logic [1:0] {MODE_BYPASS, MODE_PROG, MODE_GAUSS, MODE_EDGE} mode_t;
  typedef logic signed [COEFF_W_MAX-1:0] coeff_t;
  typedef logic signed [17:0] acc_t;
  localparam coeff_t GAUSS_K [9] = '{16'sd1, 16'sd2, 16'sd1, 16'sd2, 16'sd4, 16'sd2, 16'sd1, 16'sd2, 16'sd1};
  localparam logic [3:0] GAUSS_SHIFT = 4'd4;
  localparam coeff_t IDENT_K [9] = '{16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd1, 16'sd0, 16'sd0, 16'sd0, 16'sd0};
  function automatic acc_t mac9(input coeff_t k [9], input logic [5:0] p [9]);
    acc_t s;
    s = '0;
    for (int i = 0; i < 9; i++) s = s + acc_t'(k[i]) * acc_t'({12'd0, p[i]});
    return s;
  endfunction
  function automatic acc_t sat(input acc_t s, input logic [3:0] sh, input logic abs_en, input acc_t mx);
    acc_t t;
    t = (abs_en && s[17]) ? -s : s;
    t = t >>> sh;
    return t[17] ? '0 : (t > mx ? mx : t);
  endfunction
endpackage

// File: rtl/conv_line_window.sv
// conv_line_window: two line stores plus a 3x3 pixel window, advancing on valid input
// Ports: clk (clock), valid/hcount/pixel (input stream), win[9] (row-major window, 0 = top-left,
// rows v-2..v, columns h-2..h). Column history is cleared when hcount is 0.
module conv_line_window #(
  parameter int HRES = 1280
) (
  input  logic        clk,
  input  logic        valid,
  input  logic [10:0] hcount,
  input  logic [15:0] pixel,
  output logic [15:0] win [9]
);
  localparam int AW = $clog2(HRES);
  logic [15:0] ls0 [HRES];
  logic [15:0] ls1 [HRES];
  logic [AW-1:0] a;
  logic [15:0] col [3];
  assign a = hcount[AW-1:0];
  assign col[0] = ls1[a];
  assign col[1] = ls0[a];
  assign col[2] = pixel;
  always_ff @(posedge clk)
    if (valid && hcount < 11'(HRES)) begin
      ls1[a] <= ls0[a];
      ls0[a] <= pixel;
    end
  always_ff @(posedge clk)
    if (valid)
      for (int r = 0; r < 3; r++) begin
        win[r*3]   <= hcount == '0 ? '0 : win[r*3+1];
        win[r*3+1] <= hcount == '0 ? '0 : win[r*3+2];
        win[r*3+2] <= col[r];
      end
endmodule

// File: rtl/conv_filter.sv
// conv_filter: 3x3 RGB565 convolution filter with programmable, Gaussian and bypass modes
// Ports: clk_in, rst_in (sync active-high); data_valid_in, pixel_data_in, hcount_in, vcount_in (input stream);
// mode_in (0 bypass, 1 programmable, 2 Gaussian, 3 abs-edge or bypass); coeff_we_in/addr_in/data_in
// (staging writes: 0..8 taps, 9 shift); data_valid_out, pixel_data_out, hcount_out, vcount_out (centre h-1,v-1).
// Macro CONV_FILTER_ABS_EDGE_EN enables mode 3 as abs-valued programmable kernel; otherwise mode 3 bypasses.
module conv_filter
  import conv_filter_pkg::*;
#(
  parameter int HRES = 1280,
  parameter int VRES = 720,
  parameter int COEFF_W = 8
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               data_valid_in,
  input  logic [15:0]        pixel_data_in,
  input  logic [10:0]        hcount_in,
  input  logic [9:0]         vcount_in,
  input  logic [1:0]         mode_in,
  input  logic               coeff_we_in,
  input  logic [3:0]         coeff_addr_in,
  input  logic [COEFF_W-1:0] coeff_data_in,
  output logic               data_valid_out,
  output logic [15:0]        pixel_data_out,
  output logic [10:0]        hcount_out,
  output logic [9:0]         vcount_out
);
  coeff_t stg_k [9];
  coeff_t stg_k_n [9];
  coeff_t act_k [9];
  coeff_t k [9];
  logic [3:0] stg_sh, stg_sh_n, act_sh, sh, s2_sh;
  mode_t act_mode;
  logic started, first, qual, use_conv, abs_mode;
  logic [15:0] win [9];
  logic [5:0] pr [9];
  logic [5:0] pg [9];
  logic [5:0] pb [9];
  logic vld [LATENCY];
  logic [10:0] hc [LATENCY];
  logic [9:0] vc [LATENCY];
  logic s1_byp, s2_byp, s2_abs;
  logic [15:0] s2_ctr, s3_pix;
  acc_t s2_sum [3];
  assign first = data_valid_in && hcount_in == '0 && vcount_in == '0;
  assign qual = data_valid_in && started && hcount_in != '0 && vcount_in != '0 &&
                hcount_in < 11'(HRES) && vcount_in < 10'(VRES);
  assign data_valid_out = vld[LATENCY-1];
  assign hcount_out = hc[LATENCY-1];
  assign vcount_out = vc[LATENCY-1];
  conv_line_window #(.HRES(HRES)) u_win (
    .clk(clk_in),
    .valid(data_valid_in),
    .hcount(hcount_in),
    .pixel(pixel_data_in),
    .win(win)
  );
  always_comb begin
    stg_k_n = stg_k;
    stg_sh_n = stg_sh;
    if (coeff_we_in && coeff_addr_in < 4'd9) stg_k_n[coeff_addr_in] = coeff_t'($signed(coeff_data_in));
    if (coeff_we_in && coeff_addr_in == 4'd9) stg_sh_n = coeff_data_in[3:0];
  end
  always_ff @(posedge clk_in)
    if (rst_in) begin
      stg_k <= IDENT_K;
      stg_sh <= '0;
      act_k <= IDENT_K;
      act_sh <= '0;
      act_mode <= MODE_BYPASS;
      started <= 1'b0;
    end else begin
      stg_k <= stg_k_n;
      stg_sh <= stg_sh_n;
      if (first) begin
        act_k <= stg_k_n;
        act_sh <= stg_sh_n;
        act_mode <= mode_t'(mode_in);
        started <= 1'b1;
      end
    end
  always_comb begin
    for (int i = 0; i < 9; i++) begin
      pr[i] = {1'b0, win[i][15:11]};
      pg[i] = win[i][10:5];
      pb[i] = {1'b0, win[i][4:0]};
      k[i] = act_mode == MODE_GAUSS ? GAUSS_K[i] : act_k[i];
    end
    sh = act_mode == MODE_GAUSS ? GAUSS_SHIFT : act_sh;
`ifdef CONV_FILTER_ABS_EDGE_EN
    abs_mode = act_mode == MODE_EDGE;
    use_conv = act_mode != MODE_BYPASS;
`else
    abs_mode = 1'b0;
    use_conv = act_mode == MODE_PROG || act_mode == MODE_GAUSS;
`endif
  end
  always_ff @(posedge clk_in)
    if (rst_in) begin
      vld <= '{default: 1'b0};
      hc <= '{default: '0};
      vc <= '{default: '0};
      pixel_data_out <= '0;
    end else begin
      vld[0] <= qual;
      hc[0] <= hcount_in - 11'd1;
      vc[0] <= vcount_in - 10'd1;
      for (int i = 1; i < LATENCY; i++) begin
        vld[i] <= vld[i-1];
        hc[i] <= hc[i-1];
        vc[i] <= vc[i-1];
      end
      pixel_data_out <= s3_pix;
    end
  always_ff @(posedge clk_in) begin
    s1_byp <= hcount_in == 11'd1 || vcount_in == 10'd1;
    s2_byp <= s1_byp || !use_conv;
    s2_abs <= abs_mode;
    s2_sh <= sh;
    s2_ctr <= win[4];
    s2_sum[0] <= mac9(k, pr);
    s2_sum[1] <= mac9(k, pg);
    s2_sum[2] <= mac9(k, pb);
    s3_pix <= s2_byp ? s2_ctr : {5'(sat(s2_sum[0], s2_sh, s2_abs, 18'sd31)),
                                 6'(sat(s2_sum[1], s2_sh, s2_abs, 18'sd63)),
                                 5'(sat(s2_sum[2], s2_sh, s2_abs, 18'sd31))};
  end
endmodule
